// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encoding and width constants for the PC sequencer
package pc_sequencer_pkg;
  localparam int PC_W = 30;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] DEF_RESET_PC = '0;
  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_EXEC, ST_HALT} state_t;
endpackage

// File: rtl/pc_sequencer_fetch_timer.sv
// fetch_timer: counts unacknowledged fetch cycles and flags the timeout cycle (TIMEOUT=0 disables)
module fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : en ? cnt_q + TW'(1) : cnt_q;
    expire = (TIMEOUT != 0) && en && (cnt_q == TW'(TIMEOUT - 1));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the word-PC, fetches over req/ack, presents one EXEC phase, then commits next_pc
module pc_sequencer import pc_sequencer_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    next_pc,
  input  logic               stall,
  input  logic               halt_req,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    cur_pc,
  output logic [PC_W-1:0]    link_pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [CNT_W-1:0]   retired,
  output logic               fetch_fault,
  output logic               halted
);
  state_t state_q, state_d;
  logic [PC_W-1:0] cur_pc_q, cur_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic fault_q, fault_d, in_fetch, timeout;
  assign in_fetch = state_q == ST_FETCH;
  fetch_timer #(.TIMEOUT(FETCH_TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(!in_fetch || imem_ack),
    .en(in_fetch && !imem_ack),
    .expire(timeout)
  );
  always_comb begin
    state_d = state_q;
    cur_pc_d = cur_pc_q;
    instr_d = instr_q;
    retired_d = retired_q;
    fault_d = fault_q;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH:
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end
      ST_EXEC:
        if (halt_req) begin
          retired_d = retired_q + CNT_W'(1);
          state_d = ST_HALT;
        end else if (!stall) begin
          cur_pc_d = next_pc;
          retired_d = retired_q + CNT_W'(1);
          state_d = ST_FETCH;
        end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_BOOT;
      cur_pc_q <= RESET_PC;
      instr_q <= '0;
      retired_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_pc_q <= cur_pc_d;
      instr_q <= instr_d;
      retired_q <= retired_d;
      fault_q <= fault_d;
    end
  assign imem_req = in_fetch;
  assign imem_addr = cur_pc_q;
  assign cur_pc = cur_pc_q;
  assign link_pc = cur_pc_q + PC_W'(1);
  assign instr = instr_q;
  assign instr_valid = state_q == ST_EXEC;
  assign retired = retired_q;
  assign fetch_fault = fault_q;
  assign halted = state_q == ST_HALT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus checked against a phase-level reference model
module tb_pc_sequencer;
  localparam int CW = 4;
  logic clk = 0, rst = 1;
  logic [29:0] next_pc = '0, imem_addr, cur_pc, link_pc;
  logic stall = 0, halt_req = 0, imem_ack = 0;
  logic [31:0] imem_rdata = '0, instr;
  logic imem_req, instr_valid, fetch_fault, halted;
  logic [CW-1:0] retired;
  pc_sequencer #(.RESET_PC(30'h0), .FETCH_TIMEOUT(16), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .stall(stall), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .cur_pc(cur_pc), .link_pc(link_pc), .instr(instr), .instr_valid(instr_valid),
    .retired(retired), .fetch_fault(fetch_fault), .halted(halted)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int m_ph, m_wait, m_ret;
  logic [29:0] m_pc;
  logic [31:0] m_instr;
  bit m_fault;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    logic [29:0] lp;
    lp = m_pc + 30'd1;
    chk("imem_req", 64'(imem_req), 64'(m_ph == 1));
    chk("imem_addr", 64'(imem_addr), 64'(m_pc));
    chk("cur_pc", 64'(cur_pc), 64'(m_pc));
    chk("link_pc", 64'(link_pc), 64'(lp));
    chk("instr", 64'(instr), 64'(m_instr));
    chk("instr_valid", 64'(instr_valid), 64'(m_ph == 2));
    chk("retired", 64'(retired), 64'(m_ret % (1 << CW)));
    chk("fetch_fault", 64'(fetch_fault), 64'(m_fault));
    chk("halted", 64'(halted), 64'(m_ph == 3));
  endtask
  task automatic do_reset();
    rst = 1;
    imem_ack = 0;
    stall = 0;
    halt_req = 0;
    #1;
    m_ph = 0; m_wait = 0; m_ret = 0; m_pc = '0; m_instr = '0; m_fault = 0;
    check_all();
    @(negedge clk);
    rst = 0;
  endtask
  task automatic step(input bit a, input logic [31:0] d, input bit s, input bit h, input logic [29:0] n);
    imem_ack = a; imem_rdata = d; stall = s; halt_req = h; next_pc = n;
    case (m_ph)
      0: begin m_ph = 1; m_wait = 0; end
      1: if (a) begin
           m_instr = d; m_ph = 2;
         end else begin
           m_wait++;
           if (m_wait == 16) begin m_fault = 1; m_ph = 3; end
         end
      2: if (h) begin
           m_ret++; m_ph = 3;
         end else if (!s) begin
           m_pc = n; m_ret++; m_ph = 1; m_wait = 0;
         end
      default: ;
    endcase
    @(negedge clk);
    check_all();
  endtask
  initial begin
    do_reset();
    step(0, 0, 0, 0, 30'h2A);
    step(1, 32'h2008_0005, 0, 0, 0);
    step(0, 0, 0, 0, 30'd1);
    repeat (3) step(0, $urandom, 0, 0, 30'($urandom));
    step(1, $urandom, 0, 0, 0);
    repeat (5) step(1, $urandom, 1, 0, 30'($urandom));
    step(0, 0, 0, 0, 30'h155);
    repeat (16) step(0, $urandom, 0, 0, 0);
    repeat (3) step(1, $urandom, 0, 1, 30'($urandom));
    do_reset();
    step(0, 0, 0, 0, 0);
    repeat (15) step(0, 0, 0, 0, 0);
    step(1, 32'hDEAD_BEEF, 0, 0, 0);
    step(0, 0, 0, 0, 30'h3FFF_FFFF);
    step(1, $urandom, 0, 0, 0);
    step(0, 0, 0, 0, 30'd5);
    step(1, $urandom, 0, 0, 0);
    step(0, 0, 1, 1, 30'($urandom));
    repeat (3) step(1, $urandom, 0, 0, 30'($urandom));
    do_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    do_reset();
    repeat (1500) begin
      if ((m_ph == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) do_reset();
      else step(bit'($urandom_range(0, 1)), $urandom, $urandom_range(0, 9) < 3,
                $urandom_range(0, 59) == 0, 30'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
